mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_master.sv | 158 +++++++++++++++
 tb/tb_mem_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_master load/store bus master.
// Contents: size_t (request size encoding), state_t (master FSM states),
// byte-lane mask constants and a request legality helper.
package mem_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned CNT_BITS  = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [LANES-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [LANES-1:0] BE_WORD    = 4'b1111;

  // Natural alignment check; size 3 is never legal.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size_t'(size))
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for mem_master.
// Store side: st_size/st_lane/st_wdata -> st_be (byte enables) and
//             st_data (lane-replicated store data).
// Load side:  ld_size/ld_lane/ld_signed/ld_rdata -> ld_data (lane
//             extracted, zero/sign extended to 32 bits).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_lane,
  input  logic [WORD_BITS-1:0] st_wdata,
  output logic [LANES-1:0]     st_be,
  output logic [WORD_BITS-1:0] st_data,
  input  logic [1:0]           ld_size,
  input  logic [1:0]           ld_lane,
  input  logic                 ld_signed,
  input  logic [WORD_BITS-1:0] ld_rdata,
  output logic [WORD_BITS-1:0] ld_data
);

  logic [WORD_BITS-1:0] ld_shift;

  // Byte enables and store replication.
  always_comb begin
    st_be   = '0;
    st_data = st_wdata;
    case (size_t'(st_size))
      SZ_BYTE: begin
        st_be   = BE_BYTE0 << st_lane;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = st_lane[1] ? BE_HALF_HI : BE_HALF_LO;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: st_be = BE_WORD;
      default: st_be = '0;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift = ld_rdata >> {ld_lane, 3'b000};
    ld_data  = '0;
    case (size_t'(ld_size))
      SZ_BYTE: ld_data = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      SZ_WORD: ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding load/store master onto a waitrequest-style memory bus.
// Request side:  req_valid/req_ready handshake with req_wr, req_addr,
//                req_size, req_signed, req_wdata.
// Response side: one-cycle resp_valid pulse with resp_rdata and resp_err.
// Memory side:   mem_addr (word aligned), mem_wr_data, mem_wr_be, mem_rd,
//                mem_wr strobes, mem_rd_data, mem_waitrequest stall.
// All outputs are registered; reset is synchronous and active high.
module mem_master
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_waitrequest
);

  localparam logic [CNT_BITS-1:0] TIMEOUT_CNT = CNT_BITS'(TIMEOUT);

  state_t                state_q;
  logic [CNT_BITS-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]            size_q, lane_q;
  logic                  signed_q, wr_q;

  logic                  req_ready_q, resp_valid_q, resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q, mem_wr_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [BE_WIDTH-1:0]   mem_wr_be_q;
  logic                  mem_rd_q, mem_wr_q;

  logic                  legal_c;
  logic [LANES-1:0]      be_c;
  logic [WORD_BITS-1:0]  wdata_c, rdata_c;

  assign legal_c = req_legal(req_size, req_addr[1:0]);

  // Store steering uses the live request; load steering uses the captured one.
  mem_lane_align u_align (
    .st_size   (req_size),
    .st_lane   (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_be     (be_c),
    .st_data   (wdata_c),
    .ld_size   (size_q),
    .ld_lane   (lane_q),
    .ld_signed (signed_q),
    .ld_rdata  (mem_rd_data),
    .ld_data   (rdata_c)
  );

  // Stall counter: counts waitrequest cycles of the current bus transfer.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (mem_waitrequest) wait_cnt_d = wait_cnt_q + CNT_BITS'(1);
  end

  // Master FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      size_q        <= '0;
      lane_q        <= '0;
      signed_q      <= 1'b0;
      wr_q          <= 1'b0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_be_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (legal_c) begin
              state_q       <= ST_BUS;
              wait_cnt_q    <= '0;
              size_q        <= req_size;
              lane_q        <= req_addr[1:0];
              signed_q      <= req_signed;
              wr_q          <= req_wr;
              mem_addr_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wr_data_q <= DATA_WIDTH'(wdata_c);
              mem_wr_be_q   <= BE_WIDTH'(be_c);
              mem_rd_q      <= ~req_wr;
              mem_wr_q      <= req_wr;
            end else begin
              // Illegal request: error response without touching the bus.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          wait_cnt_q <= wait_cnt_d;
          if (!mem_waitrequest) begin
            state_q      <= ST_RESP;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= wr_q ? '0 : DATA_WIDTH'(rdata_c);
          end else if (wait_cnt_d == TIMEOUT_CNT) begin
            state_q      <= ST_RESP;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_be   = mem_wr_be_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: transaction-level model checked every
// cycle, plus directed transactions with hand-computed literal results.
module tb_mem_master;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rd_data = '0;
  logic        mem_waitrequest = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .TIMEOUT(TMO)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wr          (req_wr),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_be       (mem_wr_be),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_rd_data     (mem_rd_data),
    .mem_waitrequest (mem_waitrequest)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference behaviour, plain arithmetic ----------------
  function automatic logic mdl_legal(input logic [1:0] size, input logic [31:0] addr);
    int n = 1 << size;
    if (size == 2'd3) return 1'b0;
    return (addr % n) == 0;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [1:0] size, input logic [1:0] lane);
    int n = 1 << size;
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [1:0] size, input logic [31:0] wd);
    int n = 1 << size;
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_rdata(input logic [1:0] size, input logic [1:0] lane,
                                            input logic sgn, input logic [31:0] rd);
    int n = 1 << size;
    logic [31:0] mask, v;
    if (size == 2'd2) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * lane)) & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  logic        rst_edge = 1'b1;
  always @(posedge clock) rst_edge <= reset;

  logic        m_ready = 1'b0, m_bus = 1'b0, m_resp = 1'b0, m_wr = 1'b0, m_err = 1'b0, m_sgn = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;
  logic [1:0]  m_size = '0, m_lane = '0;
  int          m_nbus = 0;

  always @(negedge clock) begin
    logic n_ready, n_bus, n_resp;
    if (rst_edge) begin
      chk("rst_ctl", {27'd0, req_ready, resp_valid, resp_err, mem_rd, mem_wr}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wr_data, 32'd0);
      chk("rst_be", {28'd0, mem_wr_be}, 32'd0);
      m_ready = 1'b1;
      m_bus   = 1'b0;
      m_resp  = 1'b0;
    end else begin
      chk("ready", {31'd0, req_ready}, {31'd0, m_ready});
      chk("mem_rd", {31'd0, mem_rd}, {31'd0, m_bus & ~m_wr});
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, m_bus & m_wr});
      if (m_bus) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_be", {28'd0, mem_wr_be}, {28'd0, m_be});
        if (m_wr) chk("mem_wdata", mem_wr_data, m_data);
      end
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
      if (m_resp) begin
        chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      n_ready = m_ready | m_resp;
      n_bus   = 1'b0;
      n_resp  = 1'b0;
      if (m_ready && req_valid) begin
        n_ready = 1'b0;
        m_wr    = req_wr;
        m_size  = req_size;
        m_lane  = req_addr[1:0];
        m_sgn   = req_signed;
        if (mdl_legal(req_size, req_addr)) begin
          m_addr = req_addr & ~32'd3;
          m_be   = mdl_be(req_size, req_addr[1:0]);
          m_data = mdl_wdata(req_size, req_wdata);
          m_nbus = 0;
          n_bus  = 1'b1;
        end else begin
          n_resp  = 1'b1;
          m_err   = 1'b1;
          m_rdata = '0;
        end
      end
      if (m_bus) begin
        m_nbus++;
        if (!mem_waitrequest) begin
          n_resp  = 1'b1;
          m_err   = 1'b0;
          m_rdata = m_wr ? 32'd0 : mdl_rdata(m_size, m_lane, m_sgn, mem_rd_data);
        end else if (m_nbus == TMO) begin
          n_resp  = 1'b1;
          m_err   = 1'b1;
          m_rdata = '0;
        end else begin
          n_bus = 1'b1;
        end
      end
      m_ready = n_ready;
      m_bus   = n_bus;
      m_resp  = n_resp;
    end
  end

  // ---------------- directed transaction driver ----------------
  int          r_lat, r_strobe;
  logic        r_err;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  // Starts and ends at posedge+1. nwait = number of stalled bus cycles.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int nwait);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata; mem_rd_data = rdata;
    mem_waitrequest = (nwait > 0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    r_lat = -1; r_strobe = 0; r_err = 1'b0; r_rdata = 'x;
    for (int k = 1; k <= 40; k++) begin
      mem_waitrequest = (k <= nwait);
      @(negedge clock);
      if (mem_rd || mem_wr) begin
        r_strobe++;
        r_addr = mem_addr; r_be = mem_wr_be; r_wdata = mem_wr_data;
      end
      if (resp_valid) begin
        r_lat = k; r_err = resp_err; r_rdata = resp_rdata;
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
    end
    mem_waitrequest = 1'b0;
    chk("resp_seen", (r_lat > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Store WORD, no stall.
    run_req(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_lat", 32'(r_lat), 32'd2);
    chk("sw_strobe", 32'(r_strobe), 32'd1);
    chk("sw_be", {28'd0, r_be}, 32'hF);
    chk("sw_data", r_wdata, 32'hDEADBEEF);
    chk("sw_err", {31'd0, r_err}, 32'd0);

    // Load BYTE signed with 3 stall cycles.
    run_req(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 32'h80FF_1234, 3);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_strobe", 32'(r_strobe), 32'd4);
    chk("lb_lat", 32'(r_lat), 32'd5);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);

    // Store HALF upper lanes, then load it back unsigned.
    run_req(1'b1, 32'h206, 2'd1, 1'b0, 32'h0000ABCD, 32'h0, 0);
    chk("sh_be", {28'd0, r_be}, 32'hC);
    chk("sh_data", r_wdata, 32'hABCDABCD);
    chk("sh_addr", r_addr, 32'h204);
    run_req(1'b0, 32'h206, 2'd1, 1'b0, 32'h0, 32'hABCD0000, 0);
    chk("lh_rdata", r_rdata, 32'h0000ABCD);

    // Illegal requests: misaligned WORD, size 3, odd HALF.
    run_req(1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 32'h12345678, 0);
    chk("ill_word_lat", 32'(r_lat), 32'd1);
    chk("ill_word_err", {31'd0, r_err}, 32'd1);
    chk("ill_word_strobe", 32'(r_strobe), 32'd0);
    chk("ill_word_rdata", r_rdata, 32'd0);
    run_req(1'b0, 32'h200, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    chk("ill_size_err", {31'd0, r_err}, 32'd1);
    chk("ill_size_strobe", 32'(r_strobe), 32'd0);
    run_req(1'b1, 32'h301, 2'd1, 1'b0, 32'h1111, 32'h0, 0);
    chk("ill_half_err", {31'd0, r_err}, 32'd1);

    // More lane/extension cases.
    run_req(1'b0, 32'h102, 2'd0, 1'b0, 32'h0, 32'h80FF_1234, 1);
    chk("lbu_rdata", r_rdata, 32'h000000FF);
    run_req(1'b0, 32'h100, 2'd1, 1'b1, 32'h0, 32'h1234_8001, 0);
    chk("lhs_rdata", r_rdata, 32'hFFFF8001);
    run_req(1'b1, 32'h102, 2'd0, 1'b0, 32'h12345677, 32'h0, 0);
    chk("sb_be", {28'd0, r_be}, 32'h4);
    chk("sb_data", r_wdata, 32'h77777777);
    run_req(1'b0, 32'h400, 2'd2, 1'b1, 32'h0, 32'h8765_4321, 2);
    chk("lw_rdata", r_rdata, 32'h87654321);

    // Timeout: waitrequest never drops.
    run_req(1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 32'h55AA55AA, 100);
    chk("tmo_strobe", 32'(r_strobe), 32'd4);
    chk("tmo_lat", 32'(r_lat), 32'd5);
    chk("tmo_err", {31'd0, r_err}, 32'd1);
    chk("tmo_rdata", r_rdata, 32'd0);

    // Reset in the second bus cycle of a stalled store.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h500; req_size = 2'd2;
    req_wdata = 32'hCAFEF00D; mem_waitrequest = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst_bus1_wr", {31'd0, mem_wr}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_bus2_wr", {31'd0, mem_wr}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_after_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_after_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    mem_waitrequest = 1'b0;
    @(negedge clock);
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rel_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clock); #1;

    // Recovery after the abandoned transfer.
    run_req(1'b1, 32'h600, 2'd2, 1'b0, 32'h01020304, 32'h0, 1);
    chk("rec_lat", 32'(r_lat), 32'd3);
    chk("rec_addr", r_addr, 32'h600);
    chk("rec_err", {31'd0, r_err}, 32'd0);

    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
